// File: rtl/sdram_aref_if.sv
// Arbiter handshake and SDRAM command/address bus of the auto-refresh generator.
// AREF_OVERRUN_EN adds the aref_overrun status output.
`timescale 1ns/1ps
interface sdram_aref_if #(
    parameter int ADDR_W = 12
);
    logic              init_done;
    logic              aref_en;
    logic              aref_req;
    logic              aref_end;
    logic [3:0]        sdram_cmd;
    logic [1:0]        sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
`ifdef AREF_OVERRUN_EN
    logic              aref_overrun;

    modport master (
        input  init_done, aref_en,
        output aref_req, aref_end, sdram_cmd, sdram_ba, sdram_addr, aref_overrun
    );
    modport slave (
        output init_done, aref_en,
        input  aref_req, aref_end, sdram_cmd, sdram_ba, sdram_addr, aref_overrun
    );
`else
    modport master (
        input  init_done, aref_en,
        output aref_req, aref_end, sdram_cmd, sdram_ba, sdram_addr
    );
    modport slave (
        output init_done, aref_en,
        input  aref_req, aref_end, sdram_cmd, sdram_ba, sdram_addr
    );
`endif
endinterface

// File: rtl/sdram_aref.sv
// Periodic SDRAM auto-refresh: PRECHARGE ALL then two AUTO REFRESH per interval.
// Define AREF_OVERRUN_EN to add the sticky missed-deadline flag aref_overrun.
`timescale 1ns/1ps
module sdram_aref #(
    parameter int REF_INTERVAL = 750,
    parameter int T_RP         = 2,
    parameter int T_RC         = 4,
    parameter int ADDR_W       = 12
) (
    input  logic         clock,
    input  logic         reset,
    sdram_aref_if.master bus
);
    localparam int CNT_W    = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int WAIT_MAX = (T_RP > T_RC) ? T_RP : T_RC;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [3:0]        CMD_NOP   = 4'b0111;
    localparam logic [3:0]        CMD_PRE   = 4'b0010;
    localparam logic [3:0]        CMD_AREF  = 4'b0001;
    localparam logic [ADDR_W-1:0] ADDR_A10  = ADDR_W'(1024);

    typedef enum logic [2:0] {
        IDLE, PRE, WAIT_RP, AREF1, WAIT_RC1, AREF2, WAIT_RC2, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                end_q, end_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wrap;

    // Interval counter runs only while init_done is high, regardless of FSM state
    always_comb begin
        cnt_d = '0;
        wrap  = 1'b0;
        if (bus.init_done) begin
            if (cnt_q == CNT_W'(REF_INTERVAL - 1)) wrap = 1'b1;
            else                                   cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: if (req_q && bus.aref_en) begin
                state_d = PRE;
                wait_d  = WAIT_W'(T_RP - 1);
            end
            PRE, WAIT_RP: if (wait_q == '0) begin
                state_d = AREF1;
                wait_d  = WAIT_W'(T_RC - 1);
            end else begin
                state_d = WAIT_RP;
                wait_d  = wait_q - WAIT_W'(1);
            end
            AREF1, WAIT_RC1: if (wait_q == '0) begin
                state_d = AREF2;
                wait_d  = WAIT_W'(T_RC - 1);
            end else begin
                state_d = WAIT_RC1;
                wait_d  = wait_q - WAIT_W'(1);
            end
            AREF2, WAIT_RC2: if (wait_q == '0) begin
                state_d = DONE;
            end else begin
                state_d = WAIT_RC2;
                wait_d  = wait_q - WAIT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Set on wrap beats the clear on grant; init_done low overrides both
    always_comb begin
        req_d = req_q;
        if (state_q == IDLE && state_d != IDLE) req_d = 1'b0;
        if (wrap)                               req_d = 1'b1;
        if (!bus.init_done)                     req_d = 1'b0;
    end

    // Outputs decoded from the next state so the registered bus lines up with the state
    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
        end_d  = 1'b0;
        case (state_d)
            PRE: begin
                cmd_d  = CMD_PRE;
                addr_d = ADDR_A10;
            end
            AREF1, AREF2: cmd_d = CMD_AREF;
            DONE:         end_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            end_q   <= 1'b0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            end_q   <= end_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
        end
    end

`ifdef AREF_OVERRUN_EN
    logic ovr_q, ovr_d;

    // A wrap while a refresh is still pending or running means a deadline was missed
    always_comb begin
        ovr_d = ovr_q | (wrap & (req_q | (state_q != IDLE)));
    end

    always_ff @(posedge clock) begin
        if (reset) ovr_q <= 1'b0;
        else       ovr_q <= ovr_d;
    end

    assign bus.aref_overrun = ovr_q;
`endif

    assign bus.aref_req   = req_q;
    assign bus.aref_end   = end_q;
    assign bus.sdram_cmd  = cmd_q;
    assign bus.sdram_ba   = 2'b00;
    assign bus.sdram_addr = addr_q;
endmodule

// File: tb/tb_sdram_aref.sv
// Bench for sdram_aref: default instance plus a short-interval T_RP=1/T_RC=1 instance,
// both checked every cycle against a timeline model of the refresh sequence.
`timescale 1ns/1ps
module tb_sdram_aref;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PREC = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam int RI0 = 750, TRP0 = 2, TRC0 = 4;
    localparam int RI1 = 40,  TRP1 = 1, TRC1 = 1;
`ifdef AREF_OVERRUN_EN
    localparam bit HAS_OVR = 1'b1;
`else
    localparam bit HAS_OVR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, init_done, aref_en;
    int   vectors = 0, miscompares = 0;
    bit   chk_en = 1'b0;

    always #5 clock = ~clock;

    sdram_aref_if #(.ADDR_W(12)) bus0 ();
    sdram_aref_if #(.ADDR_W(12)) bus1 ();
    assign bus0.init_done = init_done;
    assign bus0.aref_en   = aref_en;
    assign bus1.init_done = init_done;
    assign bus1.aref_en   = aref_en;

    sdram_aref #(.REF_INTERVAL(RI0), .T_RP(TRP0), .T_RC(TRC0), .ADDR_W(12)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.master));
    sdram_aref #(.REF_INTERVAL(RI1), .T_RP(TRP1), .T_RC(TRC1), .ADDR_W(12)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.master));

    // Timeline model: a grant at edge k puts PRECHARGE in cycle k, refreshes at
    // k+T_RP and k+T_RP+T_RC, the end pulse at k+T_RP+2*T_RC.
    int  ri[2]      = '{RI0, RI1};
    int  trp[2]     = '{TRP0, TRP1};
    int  trc[2]     = '{TRC0, TRC1};
    int  run_len[2] = '{0, 0};
    int  seq_k[2]   = '{-1000000, -1000000};
    bit  m_req[2]   = '{1'b0, 1'b0};
    bit  m_ovr[2]   = '{1'b0, 1'b0};
    int  edge_no    = 0;
    logic [20:0] m_exp[2];

    always @(posedge clock) begin
        bit idle, wrap, grant, e;
        int d;
        logic [3:0]  c;
        logic [11:0] a;
        edge_no++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                run_len[i] = 0;
                m_req[i]   = 1'b0;
                m_ovr[i]   = 1'b0;
                seq_k[i]   = -1000000;
            end else begin
                idle = (edge_no - 1) > (seq_k[i] + trp[i] + 2 * trc[i]);
                wrap = 1'b0;
                if (init_done) begin
                    run_len[i]++;
                    wrap = (run_len[i] % ri[i]) == 0;
                end else begin
                    run_len[i] = 0;
                end
                grant = idle && m_req[i] && aref_en;
                if (wrap && (m_req[i] || !idle)) m_ovr[i] = 1'b1;
                if (grant) seq_k[i] = edge_no;
                if (!init_done)  m_req[i] = 1'b0;
                else if (wrap)   m_req[i] = 1'b1;
                else if (grant)  m_req[i] = 1'b0;
            end
            d = edge_no - seq_k[i];
            c = NOP;
            a = 12'h000;
            e = 1'b0;
            if (d == 0) begin
                c = PREC;
                a = 12'h400;
            end else if (d == trp[i] || d == trp[i] + trc[i]) begin
                c = AREF;
            end else if (d == trp[i] + 2 * trc[i]) begin
                e = 1'b1;
            end
            m_exp[i] = {m_req[i], e, m_ovr[i] & HAS_OVR, c, 2'b00, a};
        end
    end

    function automatic logic [20:0] obs(input int i);
        logic o0, o1;
        o0 = 1'b0;
        o1 = 1'b0;
`ifdef AREF_OVERRUN_EN
        o0 = bus0.aref_overrun;
        o1 = bus1.aref_overrun;
`endif
        if (i == 0)
            return {bus0.aref_req, bus0.aref_end, o0, bus0.sdram_cmd, bus0.sdram_ba, bus0.sdram_addr};
        return {bus1.aref_req, bus1.aref_end, o1, bus1.sdram_cmd, bus1.sdram_ba, bus1.sdram_addr};
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== m_exp[i]) begin
                    miscompares++;
                    $display("FAIL model_dut%0d edge %0d got %h expected %h", i, edge_no, obs(i), m_exp[i]);
                end
            end
        end
    end

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk_en = 1'b1;
            vectors++;
            if ({bus0.aref_req, bus0.aref_end, bus0.sdram_cmd, bus0.sdram_ba, bus0.sdram_addr} !== {2'b00, NOP, 2'b00, 12'h000}) begin
                miscompares++;
                $display("FAIL reset_state got req=%b end=%b cmd=%b addr=%h expected 0 0 0111 000",
                         bus0.aref_req, bus0.aref_end, bus0.sdram_cmd, bus0.sdram_addr);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            vectors++;
            if ({bus0.aref_req, bus1.aref_req, bus0.sdram_cmd, bus0.sdram_addr} !== {2'b00, NOP, 12'h000}) begin
                miscompares++;
                $display("FAIL no_init_idle cycle %0d got req=%b/%b cmd=%b addr=%h expected 0/0 0111 000",
                         c, bus0.aref_req, bus1.aref_req, bus0.sdram_cmd, bus0.sdram_addr);
            end
        end
    endtask

    task automatic test_interval();
        int rise = -1;
        bit dropped = 1'b0;
        init_done = 1'b1;
        for (int c = 1; c <= 1600; c++) begin
            @(negedge clock);
            if (rise < 0 && bus0.aref_req) rise = c;
            if (rise > 0 && !bus0.aref_req) dropped = 1'b1;
`ifdef AREF_OVERRUN_EN
            if (c == 1499 || c == 1500) begin
                vectors++;
                if (bus0.aref_overrun !== (c == 1500)) begin
                    miscompares++;
                    $display("FAIL overrun_edge cycle %0d got %b expected %b", c, bus0.aref_overrun, c == 1500);
                end
            end
`endif
        end
        vectors++;
        if (rise != 750) begin
            miscompares++;
            $display("FAIL interval_rise got cycle %0d expected 750", rise);
        end
        vectors++;
        if (dropped) begin
            miscompares++;
            $display("FAIL req_sticky got dropped=1 expected 0");
        end
    endtask

    task automatic test_sequence();
        logic [3:0]  ecmd;
        logic [11:0] eaddr;
        vectors++;
        if (bus0.aref_req !== 1'b1) begin
            miscompares++;
            $display("FAIL seq_precondition got req=%b expected 1", bus0.aref_req);
        end
        aref_en = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            ecmd  = (c == 1) ? PREC : ((c == 3 || c == 7) ? AREF : NOP);
            eaddr = (c == 1) ? 12'h400 : 12'h000;
            vectors++;
            if ({bus0.sdram_cmd, bus0.sdram_addr, bus0.aref_end, bus0.aref_req} !== {ecmd, eaddr, c == 11, 1'b0}) begin
                miscompares++;
                $display("FAIL sequence +%0d got cmd=%b addr=%h end=%b req=%b expected cmd=%b addr=%h end=%b req=0",
                         c, bus0.sdram_cmd, bus0.sdram_addr, bus0.aref_end, bus0.aref_req, ecmd, eaddr, c == 11);
            end
            if (c == 1) aref_en = 1'b0;
        end
`ifdef AREF_OVERRUN_EN
        vectors++;
        if (bus0.aref_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky got %b expected 1", bus0.aref_overrun);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int rise = -1;
        bit saw_end = 1'b0;
        for (int c = 0; c < 1000 && !bus0.aref_req; c++) @(negedge clock);
        vectors++;
        if (bus0.aref_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_wait got req=%b expected 1 within 1000 cycles", bus0.aref_req);
            return;
        end
        aref_en = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            if (c == 1) aref_en = 1'b0;
        end
        vectors++;
        if (bus0.sdram_cmd !== AREF) begin
            miscompares++;
            $display("FAIL reset_mid_aref got cmd=%b expected 0001", bus0.sdram_cmd);
        end
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if ({bus0.sdram_cmd, bus0.aref_req, bus0.aref_end, bus0.sdram_addr} !== {NOP, 2'b00, 12'h000}) begin
            miscompares++;
            $display("FAIL reset_mid_outputs got cmd=%b req=%b end=%b addr=%h expected 0111 0 0 000",
                     bus0.sdram_cmd, bus0.aref_req, bus0.aref_end, bus0.sdram_addr);
        end
        reset = 1'b0;
        for (int c = 1; c <= 800; c++) begin
            @(negedge clock);
            if (bus0.aref_end) saw_end = 1'b1;
            if (rise < 0 && bus0.aref_req) rise = c;
        end
        vectors++;
        if (saw_end || rise != 750) begin
            miscompares++;
            $display("FAIL reset_mid_recovery got end_seen=%b rise=%0d expected end_seen=0 rise=750", saw_end, rise);
        end
    endtask

    task automatic test_short_timing();
        int rise = -1;
        logic [3:0] ecmd;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (bus1.aref_req) begin
                rise = c;
                break;
            end
        end
        vectors++;
        if (rise != RI1) begin
            miscompares++;
            $display("FAIL short_rise got cycle %0d expected %0d", rise, RI1);
            return;
        end
        aref_en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            ecmd = (c == 1) ? PREC : ((c == 2 || c == 3) ? AREF : NOP);
            vectors++;
            if ({bus1.sdram_cmd, bus1.aref_end, bus1.sdram_addr} !== {ecmd, c == 4, (c == 1) ? 12'h400 : 12'h000}) begin
                miscompares++;
                $display("FAIL short_seq +%0d got cmd=%b end=%b addr=%h expected cmd=%b end=%b",
                         c, bus1.sdram_cmd, bus1.aref_end, bus1.sdram_addr, ecmd, c == 4);
            end
            if (c == 1) aref_en = 1'b0;
        end
    endtask

    task automatic test_random();
        int got_ends = 0, exp_ends = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clock);
            if (bus1.aref_end === 1'b1) got_ends++;
            if (m_exp[1][19]) exp_ends++;
            aref_en = ($urandom_range(3) == 0);
            if ($urandom_range(299) == 0) init_done = ~init_done;
            reset = ($urandom_range(999) == 0);
        end
        @(negedge clock);
        reset     = 1'b0;
        init_done = 1'b1;
        aref_en   = 1'b0;
        vectors++;
        if (got_ends != exp_ends || exp_ends == 0) begin
            miscompares++;
            $display("FAIL random_end_count got %0d expected %0d (nonzero)", got_ends, exp_ends);
        end
    endtask

    initial begin
        reset     = 1'b1;
        init_done = 1'b0;
        aref_en   = 1'b0;
        test_reset();
        test_interval();
        test_sequence();
        test_reset_mid();
        test_short_timing();
        test_random();
        repeat (2) @(negedge clock);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sdram_aref.md
Name: sdram_aref

Overview:
- Periodic auto-refresh generator that sits directly downstream of sdram_init.
- Enabled by sdram_init's init_done. Times the refresh interval and raises a request to the SDRAM command arbiter.
- On grant, drives one PRECHARGE ALL followed by two AUTO REFRESH commands onto the SDRAM command/address bus, respecting tRP/tRC.
- Signals completion to the arbiter with a one-cycle pulse.

Parameters:
- REF_INTERVAL, 750: clock cycles between refresh requests (15 us at 50 MHz; 4096 rows per 64 ms with margin).
- T_RP, 2: cycles from PRECHARGE to the first AUTO REFRESH (>=1).
- T_RC, 4: cycles from each AUTO REFRESH to the next command/end (>=1).
- ADDR_W, 12: SDRAM address width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- init_done  in  1  level from sdram_init; high once the initialisation sequence has completed.
- aref_en  in  1  arbiter grant; sampled only in IDLE with aref_req=1.
- aref_req  out  1  refresh request to the arbiter.
- aref_end  out  1  one-cycle pulse marking that the refresh sequence is complete.
- sdram_cmd  out  4  {CS_N,RAS_N,CAS_N,WE_N}.
- sdram_ba  out  2  bank address.
- sdram_addr  out  ADDR_W  address bus.

Behaviour:
- Reset values: aref_req=0, aref_end=0, sdram_cmd=4'b0111 (NOP), sdram_ba=0, sdram_addr=0, FSM=IDLE, interval counter=0.
- Commands: NOP=0111, PRECHARGE=0010, AUTO REFRESH=0001. sdram_addr=12'h400 (A10=1, all banks) only in the PRECHARGE cycle, 0 otherwise. sdram_ba is always 0. All outputs are registered.
- Interval counter:
  - Held at 0 while init_done=0.
  - Otherwise increments each cycle; on reaching REF_INTERVAL-1 it wraps to 0 and sets aref_req.
  - Free-running, independent of FSM state.
- aref_req:
  - Set on wrap; sticky.
  - Cleared in the cycle the FSM leaves IDLE.
  - Forced to 0 while init_done=0.
  - A wrap occurring in the same cycle as the clear leaves aref_req=1 (set wins).
- FSM states: IDLE, PRE, WAIT_RP, AREF1, WAIT_RC1, AREF2, WAIT_RC2, DONE.
  - IDLE -> PRE when aref_req&aref_en are sampled at edge k-1. aref_en without aref_req is ignored.
  - PRE drives PRECHARGE at cycle k. WAIT_RP runs until AREF1, which drives AUTO REFRESH at k+T_RP.
  - WAIT_RC1, then AREF2 drives AUTO REFRESH at k+T_RP+T_RC.
  - WAIT_RC2, then DONE drives aref_end=1 at k+T_RP+2*T_RC. The next cycle returns to IDLE.
  - Default timeline: PRE@1, AREF@3, AREF@7, aref_end@11.
- Non-command cycles drive NOP. A single down-counter is shared for the waits; it is loaded with T_RP-1 or T_RC-1.
- init_done falling mid-sequence: the sequence completes normally; no new request is raised.
- Reset mid-sequence: next cycle all outputs take their reset values and the FSM returns to IDLE, with no aref_end pulse.
- aref_en may stay high throughout the sequence. A new grant is honoured only after returning to IDLE.

Optional Feature:
- Macro: AREF_OVERRUN_EN.
- With the macro defined:
  - Adds output aref_overrun (1 bit, reset 0).
  - Sticky set when an interval wrap occurs while aref_req is already 1 or the FSM is not in IDLE, meaning a refresh deadline was missed.
  - Cleared only by reset.
- Without the macro: the port and its logic are absent; wraps during a pending or active refresh are silently merged.

Test Plan:
- reset=1 for 3 cycles, then init_done=0 for 2000 cycles -> aref_req stays 0, sdram_cmd=0111, addr=0 throughout.
- init_done=1 at cycle 0, aref_en=0 -> aref_req rises after exactly 750 cycles and stays high indefinitely.
- aref_req=1, aref_en pulsed 1 cycle -> PRECHARGE with addr=12'h400 at +1, AUTO REFRESH at +3 and +7, aref_end one-cycle pulse at +11, NOP elsewhere, aref_req low from +1.
- Reset asserted at the cycle of the first AUTO REFRESH -> next cycle cmd=0111, aref_end never pulses, the next request comes 750 cycles after init_done is re-seen.
- T_RP=1, T_RC=1 override -> commands at +1, +2, +3, aref_end at +4.
- AREF_OVERRUN_EN defined, aref_en held 0 for 1600 cycles after init_done -> aref_overrun=1 from the second wrap (cycle 1500) and stays 1 after a later grant; undefined build has no such port.
